chip8_mem_responder: RTL and testbench

//  Memory-side responder for the CPU's byte memory protocol: serves read requests with a registered 1-cycle ack and applies single-cycle writes.

---
 rtl/chip8_pkg.sv | 11 +
 rtl/chip8_font_rom.sv | 25 ++
 rtl/chip8_mem_responder.sv | 131 +++++++++++++
 tb/tb_chip8_mem_responder.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// Shared constants and enumerations for the CHIP-8 memory responder slice.
package chip8_pkg;

    localparam int          ADDR_W     = 12;
    localparam logic [11:0] FONT_BASE  = 12'h000;
    localparam int          FONT_BYTES = 80;

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    typedef enum logic {GNT_CPU, GNT_VID} grant_t;

endpackage

// File: rtl/chip8_font_rom.sv
// Combinational lookup of the standard CHIP-8 hex font, 16 glyphs x 5 rows.
module chip8_font_rom (
    input  logic [6:0] idx,
    output logic [7:0] data
);

    localparam logic [7:0] FONT [0:79] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    always_comb begin
        // NOTE: default first so every path assigns data and no latch is inferred.
        data = 8'h00;
        if (idx < 7'd80)
            data = FONT[idx];
    end

endmodule

// File: rtl/chip8_mem_responder.sv
// Single-port 4 KiB RAM serving CPU reads/writes and a read-only video port,
// with a font preload phase after every reset.
module chip8_mem_responder #(
    parameter int                ADDR_W     = chip8_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] FONT_BASE  = chip8_pkg::FONT_BASE,
    parameter int                FONT_BYTES = chip8_pkg::FONT_BYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_read,
    input  logic [ADDR_W-1:0] cpu_read_idx,
    output logic              cpu_read_ack,
    output logic [7:0]        cpu_read_byte,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_write_idx,
    input  logic [7:0]        cpu_write_byte,
    input  logic              vid_read,
    input  logic [ADDR_W-1:0] vid_read_idx,
    output logic              vid_read_ack,
    output logic [7:0]        vid_read_byte,
    output logic              init_done,
    output logic              err_init_write
);

    import chip8_pkg::*;

    state_t            state;
    grant_t            last_grant;
    logic [6:0]        init_cnt;
    logic [7:0]        font_byte;
    logic [7:0]        mem [0:(1 << ADDR_W) - 1];
    logic [7:0]        rd_q;
    logic [7:0]        cpu_hold;
    logic [7:0]        vid_hold;
    logic              cpu_ack_q;
    logic              vid_ack_q;
    logic              err_q;
    logic              cpu_elig;
    logic              vid_elig;
    logic              gnt_cpu;
    logic              gnt_vid;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;

    chip8_font_rom u_font_rom (
        .idx  (init_cnt),
        .data (font_byte)
    );

    // A port whose ack is showing cannot be granted again, so a held request never double-acks.
    assign cpu_elig = (state == ST_RUN) && cpu_read && !cpu_ack_q;
    assign vid_elig = (state == ST_RUN) && vid_read && !vid_ack_q;

    always_comb begin
        gnt_cpu = 1'b0;
        gnt_vid = 1'b0;
        if (state == ST_RUN && !cpu_write) begin
            if (cpu_elig && vid_elig) begin
                gnt_cpu = (last_grant == GNT_VID);
                gnt_vid = (last_grant == GNT_CPU);
            end else begin
                gnt_cpu = cpu_elig;
                gnt_vid = vid_elig;
            end
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = vid_read_idx;
        ram_wdata = cpu_write_byte;
        if (state == ST_INIT) begin
            ram_we    = !reset;
            ram_addr  = FONT_BASE + ADDR_W'(init_cnt);
            ram_wdata = font_byte;
        end else if (cpu_write) begin
            ram_we    = !reset;
            ram_addr  = cpu_write_idx;
        end else if (gnt_cpu) begin
            ram_addr  = cpu_read_idx;
        end
    end

    // NOTE: the RAM array has no reset so it maps onto block RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        rd_q <= mem[ram_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_INIT;
            init_cnt   <= 7'd0;
            last_grant <= GNT_VID;
            cpu_ack_q  <= 1'b0;
            vid_ack_q  <= 1'b0;
            cpu_hold   <= 8'h00;
            vid_hold   <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            cpu_ack_q <= gnt_cpu;
            vid_ack_q <= gnt_vid;
            if (cpu_ack_q)
                cpu_hold <= rd_q;
            if (vid_ack_q)
                vid_hold <= rd_q;
            if (gnt_cpu)
                last_grant <= GNT_CPU;
            else if (gnt_vid)
                last_grant <= GNT_VID;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 7'd1;
                if (init_cnt == 7'(FONT_BYTES - 1))
                    state <= ST_RUN;
                if (cpu_write)
                    err_q <= 1'b1;
            end
        end
    end

    // The shared RAM output is only valid in the ack cycle; afterwards each port shows its held copy.
    assign cpu_read_byte  = cpu_ack_q ? rd_q : cpu_hold;
    assign vid_read_byte  = vid_ack_q ? rd_q : vid_hold;
    assign cpu_read_ack   = cpu_ack_q;
    assign vid_read_ack   = vid_ack_q;
    assign init_done      = (state == ST_RUN);
    assign err_init_write = err_q;

endmodule

// File: tb/tb_chip8_mem_responder.sv
// Self-checking bench for chip8_mem_responder: directed scenarios plus randomized traffic
// checked against a transaction-level memory model.
module tb_chip8_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_read;
    logic [11:0] cpu_read_idx;
    logic        cpu_read_ack;
    logic [7:0]  cpu_read_byte;
    logic        cpu_write;
    logic [11:0] cpu_write_idx;
    logic [7:0]  cpu_write_byte;
    logic        vid_read;
    logic [11:0] vid_read_idx;
    logic        vid_read_ack;
    logic [7:0]  vid_read_byte;
    logic        init_done;
    logic        err_init_write;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  model_mem [0:4095];
    logic [11:0] written [$];
    int          model_last;   // 0: CPU granted most recently, 1: VID

    logic [7:0] font [0:79] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    chip8_mem_responder dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_read       (cpu_read),
        .cpu_read_idx   (cpu_read_idx),
        .cpu_read_ack   (cpu_read_ack),
        .cpu_read_byte  (cpu_read_byte),
        .cpu_write      (cpu_write),
        .cpu_write_idx  (cpu_write_idx),
        .cpu_write_byte (cpu_write_byte),
        .vid_read       (vid_read),
        .vid_read_idx   (vid_read_idx),
        .vid_read_ack   (vid_read_ack),
        .vid_read_byte  (vid_read_byte),
        .init_done      (init_done),
        .err_init_write (err_init_write)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_read       = 1'b0;
        cpu_read_idx   = 12'h000;
        cpu_write      = 1'b0;
        cpu_write_idx  = 12'h000;
        cpu_write_byte = 8'h00;
        vid_read       = 1'b0;
        vid_read_idx   = 12'h000;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 80; i++)
            model_mem[i] = font[i];
        model_last = 1;
    endtask

    task automatic apply_reset_and_init();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 200 && !init_done; i++)
            tick();
        n_checks++;
        if (init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL init_timeout: init_done=%b want 1", init_done);
        end
    endtask

    task automatic drive_write(input logic [11:0] a, input logic [7:0] d);
        cpu_write      = 1'b1;
        cpu_write_idx  = a;
        cpu_write_byte = d;
        tick();
        cpu_write      = 1'b0;
    endtask

    // Issues requests in one cycle, waits (bounded) for the acks and returns cycles-to-ack (-1 on timeout).
    task automatic run_reads(input bit do_cpu, input logic [11:0] ca,
                             input bit do_vid, input logic [11:0] va,
                             input bit do_wr, input logic [11:0] wa, input logic [7:0] wd,
                             output int cl, output int vl,
                             output logic [7:0] cb, output logic [7:0] vb);
        cl = -1;
        vl = -1;
        cb = 8'h00;
        vb = 8'h00;
        cpu_read       = do_cpu;
        cpu_read_idx   = ca;
        vid_read       = do_vid;
        vid_read_idx   = va;
        cpu_write      = do_wr;
        cpu_write_idx  = wa;
        cpu_write_byte = wd;
        for (int i = 1; i <= 20; i++) begin
            tick();
            cpu_write = 1'b0;
            if (cpu_read && cpu_read_ack) begin
                cl = i;
                cb = cpu_read_byte;
                cpu_read = 1'b0;
            end
            if (vid_read && vid_read_ack) begin
                vl = i;
                vb = vid_read_byte;
                vid_read = 1'b0;
            end
            if (!cpu_read && !vid_read)
                break;
        end
        cpu_read = 1'b0;
        vid_read = 1'b0;
        tick();
    endtask

    function automatic logic [11:0] pick_addr();
        if (written.size() == 0 || $urandom_range(0, 2) == 0)
            return 12'($urandom_range(0, 79));
        return written[$urandom_range(0, written.size() - 1)];
    endfunction

    task automatic test_reset();
        int early;
        int acks;
        int cl, vl;
        logic [7:0] cb, vb;
        clear_inputs();
        reset = 1'b1;
        tick();
        n_checks++;
        if (cpu_read_ack !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ack: got %b want 0", cpu_read_ack); end
        n_checks++;
        if (vid_read_ack !== 1'b0) begin n_fail++; $display("FAIL reset_vid_ack: got %b want 0", vid_read_ack); end
        n_checks++;
        if (cpu_read_byte !== 8'h00) begin n_fail++; $display("FAIL reset_cpu_byte: got %h want 00", cpu_read_byte); end
        n_checks++;
        if (vid_read_byte !== 8'h00) begin n_fail++; $display("FAIL reset_vid_byte: got %h want 00", vid_read_byte); end
        n_checks++;
        if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        n_checks++;
        if (err_init_write !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_init_write); end

        // A read raised during the preload must stay pending until the ports go live.
        cpu_read     = 1'b1;
        cpu_read_idx = 12'h000;
        reset        = 1'b0;
        model_reset();
        early = 0;
        acks  = 0;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (i < 80 && init_done) early++;
            if (cpu_read_ack) acks++;
        end
        n_checks++;
        if (early !== 0) begin n_fail++; $display("FAIL init_early: init_done high on %0d edges before edge 80, want 0", early); end
        n_checks++;
        if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_edge80: got %b want 1", init_done); end
        n_checks++;
        if (acks !== 0) begin n_fail++; $display("FAIL init_acked: %0d acks during init, want 0", acks); end
        tick();
        n_checks++;
        if (cpu_read_ack !== 1'b1 || cpu_read_byte !== 8'hF0) begin
            n_fail++;
            $display("FAIL pending_read: ack=%b byte=%h want ack=1 byte=F0", cpu_read_ack, cpu_read_byte);
        end
        cpu_read = 1'b0;
        model_last = 0;
        tick();
        run_reads(1, 12'h04F, 0, 12'h000, 0, 12'h000, 8'h00, cl, vl, cb, vb);
        model_last = 0;
        n_checks++;
        if (cl !== 1 || cb !== 8'h80) begin n_fail++; $display("FAIL font_last: lat=%0d byte=%h want lat=1 byte=80", cl, cb); end
        n_checks++;
        if (err_init_write !== 1'b0) begin n_fail++; $display("FAIL err_after_init: got %b want 0", err_init_write); end
    endtask

    task automatic test_write_read();
        int cl, vl;
        logic [7:0] cb, vb;
        drive_write(12'h200, 8'hA2);
        model_mem[12'h200] = 8'hA2;
        written.push_back(12'h200);
        cpu_read     = 1'b1;
        cpu_read_idx = 12'h200;
        tick();
        n_checks++;
        if (cpu_read_ack !== 1'b1 || cpu_read_byte !== 8'hA2) begin
            n_fail++;
            $display("FAIL wr_rd_ack: ack=%b byte=%h want ack=1 byte=A2", cpu_read_ack, cpu_read_byte);
        end
        tick();
        n_checks++;
        if (cpu_read_ack !== 1'b0) begin n_fail++; $display("FAIL wr_rd_ack_width: ack=%b want 0 while request held", cpu_read_ack); end
        cpu_read = 1'b0;
        model_last = 0;
        tick();
        run_reads(0, 12'h000, 1, 12'h005, 0, 12'h000, 8'h00, cl, vl, cb, vb);
        model_last = 1;
        n_checks++;
        if (vl !== 1 || vb !== 8'h20) begin n_fail++; $display("FAIL vid_font: lat=%0d byte=%h want lat=1 byte=20", vl, vb); end
        n_checks++;
        if (cpu_read_byte !== 8'hA2) begin n_fail++; $display("FAIL cpu_byte_hold: got %h want A2", cpu_read_byte); end
    endtask

    task automatic test_arbitration();
        int cl, vl;
        logic [7:0] cb, vb;
        apply_reset_and_init();
        drive_write(12'h200, 8'h11);
        drive_write(12'h300, 8'h22);
        model_mem[12'h200] = 8'h11;
        model_mem[12'h300] = 8'h22;
        written.push_back(12'h300);
        run_reads(1, 12'h200, 1, 12'h300, 0, 12'h000, 8'h00, cl, vl, cb, vb);
        model_last = 1;
        n_checks++;
        if (cl !== 1 || cb !== 8'h11) begin n_fail++; $display("FAIL arb_cpu_first: lat=%0d byte=%h want lat=1 byte=11", cl, cb); end
        n_checks++;
        if (vl !== 2 || vb !== 8'h22) begin n_fail++; $display("FAIL arb_vid_second: lat=%0d byte=%h want lat=2 byte=22", vl, vb); end
        // After a lone CPU grant the next contended cycle must favour VID.
        run_reads(1, 12'h300, 0, 12'h000, 0, 12'h000, 8'h00, cl, vl, cb, vb);
        model_last = 0;
        run_reads(1, 12'h300, 1, 12'h200, 0, 12'h000, 8'h00, cl, vl, cb, vb);
        model_last = 0;
        n_checks++;
        if (vl !== 1 || cl !== 2) begin n_fail++; $display("FAIL arb_round_robin: vid_lat=%0d cpu_lat=%0d want 1 and 2", vl, cl); end
        n_checks++;
        if (cb !== 8'h22 || vb !== 8'h11) begin n_fail++; $display("FAIL arb_rr_data: cpu=%h vid=%h want 22 and 11", cb, vb); end
    endtask

    task automatic test_write_collision();
        int cl, vl;
        logic [7:0] cb, vb;
        model_mem[12'h250] = 8'h5A;
        written.push_back(12'h250);
        run_reads(1, 12'h250, 0, 12'h000, 1, 12'h250, 8'h5A, cl, vl, cb, vb);
        model_last = 0;
        n_checks++;
        if (cl !== 2 || cb !== 8'h5A) begin n_fail++; $display("FAIL collision: lat=%0d byte=%h want lat=2 byte=5A", cl, cb); end
    endtask

    task automatic test_reset_mid_init();
        int early;
        int cl, vl;
        logic [7:0] cb, vb;
        drive_write(12'h400, 8'h77);
        model_mem[12'h400] = 8'h77;
        cpu_read     = 1'b1;
        cpu_read_idx = 12'h400;
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (cpu_read_ack !== 1'b0 || cpu_read_byte !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset_drop: ack=%b byte=%h want ack=0 byte=00", cpu_read_ack, cpu_read_byte);
        end
        cpu_read = 1'b0;
        tick();
        reset = 1'b0;
        repeat (40) tick();
        n_checks++;
        if (init_done !== 1'b0) begin n_fail++; $display("FAIL mid_init_done: got %b want 0", init_done); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        early = 0;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (i < 80 && init_done) early++;
            cpu_write      = (i == 10);
            cpu_write_idx  = 12'h400;
            cpu_write_byte = 8'hEE;
        end
        cpu_write = 1'b0;
        n_checks++;
        if (early !== 0 || init_done !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_init: early=%0d init_done=%b want 0 and 1", early, init_done);
        end
        n_checks++;
        if (err_init_write !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err_init_write); end
        run_reads(1, 12'h200, 0, 12'h000, 0, 12'h000, 8'h00, cl, vl, cb, vb);
        n_checks++;
        if (cb !== model_mem[12'h200]) begin n_fail++; $display("FAIL survive_200: got %h want %h", cb, model_mem[12'h200]); end
        run_reads(1, 12'h400, 0, 12'h000, 0, 12'h000, 8'h00, cl, vl, cb, vb);
        model_last = 0;
        n_checks++;
        if (cb !== 8'h77) begin n_fail++; $display("FAIL init_write_dropped: got %h want 77", cb); end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        logic [7:0] b1, b2;
        drive_write(12'hFFF, 8'hC3);
        model_mem[12'hFFF] = 8'hC3;
        written.push_back(12'hFFF);
        t1 = -1;
        t2 = -1;
        b1 = 8'h00;
        b2 = 8'h00;
        cpu_read     = 1'b1;
        cpu_read_idx = 12'hFFF;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (cpu_read_ack) begin
                if (t1 < 0) begin
                    t1 = i;
                    b1 = cpu_read_byte;
                    cpu_read_idx = 12'h000;
                end else begin
                    t2 = i;
                    b2 = cpu_read_byte;
                    break;
                end
            end
        end
        cpu_read = 1'b0;
        model_last = 0;
        tick();
        n_checks++;
        if (b1 !== 8'hC3) begin n_fail++; $display("FAIL top_addr: got %h want C3", b1); end
        n_checks++;
        if (b2 !== 8'hF0) begin n_fail++; $display("FAIL wrap_addr0: got %h want F0", b2); end
        n_checks++;
        if (t1 < 0 || t2 - t1 !== 2) begin n_fail++; $display("FAIL b2b_spacing: acks at %0d and %0d want 2 apart", t1, t2); end
    endtask

    task automatic test_random();
        int cl, vl, op;
        bit cpu_first, port;
        logic [11:0] a, va, wa;
        logic [7:0] wd, cb, vb, ec, ev;
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: begin
                    wa = 12'($urandom_range('h50, 'hFFF));
                    wd = 8'($urandom);
                    drive_write(wa, wd);
                    model_mem[wa] = wd;
                    written.push_back(wa);
                end
                1, 2: begin
                    a = pick_addr();
                    ec = model_mem[a];
                    run_reads(op == 1, a, op == 2, a, 0, 12'h000, 8'h00, cl, vl, cb, vb);
                    model_last = (op == 2) ? 1 : 0;
                    n_checks++;
                    if ((op == 1 ? cl : vl) !== 1 || (op == 1 ? cb : vb) !== ec) begin
                        n_fail++;
                        $display("FAIL rand_single it=%0d port=%0d addr=%h: lat=%0d/%0d got %h/%h want lat=1 byte=%h",
                                 it, op, a, cl, vl, cb, vb, ec);
                    end
                end
                3: begin
                    a  = pick_addr();
                    va = pick_addr();
                    ec = model_mem[a];
                    ev = model_mem[va];
                    cpu_first = (model_last == 1);
                    run_reads(1, a, 1, va, 0, 12'h000, 8'h00, cl, vl, cb, vb);
                    model_last = cpu_first ? 1 : 0;
                    n_checks++;
                    if (cl !== (cpu_first ? 1 : 2) || vl !== (cpu_first ? 2 : 1)) begin
                        n_fail++;
                        $display("FAIL rand_order it=%0d: cpu_lat=%0d vid_lat=%0d want cpu_first=%0d", it, cl, vl, cpu_first);
                    end
                    n_checks++;
                    if (cb !== ec || vb !== ev) begin
                        n_fail++;
                        $display("FAIL rand_dual_data it=%0d: cpu=%h vid=%h want %h and %h", it, cb, vb, ec, ev);
                    end
                end
                default: begin
                    wa = 12'($urandom_range('h50, 'hFFF));
                    wd = 8'($urandom);
                    a  = ($urandom_range(0, 1) == 1) ? wa : pick_addr();
                    model_mem[wa] = wd;
                    written.push_back(wa);
                    ec = model_mem[a];
                    port = 1'($urandom_range(0, 1));
                    run_reads(!port, a, port, a, 1, wa, wd, cl, vl, cb, vb);
                    model_last = port ? 1 : 0;
                    n_checks++;
                    if ((port ? vl : cl) !== 2 || (port ? vb : cb) !== ec) begin
                        n_fail++;
                        $display("FAIL rand_collide it=%0d port=%0d addr=%h: lat=%0d/%0d got %h/%h want lat=2 byte=%h",
                                 it, port, a, cl, vl, cb, vb, ec);
                    end
                end
            endcase
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        model_last = 1;
        test_reset();
        test_write_read();
        test_arbitration();
        test_write_collision();
        test_reset_mid_init();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
